// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: decodes opcode/funct and drives datapath selects and write
// enables cycle by cycle, with memory-ready stalls and a retired-instruction counter.
module mips_multicycle_control (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  pc_source,
    output logic [1:0]  ext_mode,
    output logic        instr_done,
    output logic        trap,
    output logic [3:0]  state,
    output logic [31:0] retired_count
);

    typedef enum logic [3:0] {
        StReset  = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StImmEx  = 4'd10,
        StImmWb  = 4'd11,
        StJump   = 4'd12,
        StTrap   = 4'd13
    } state_e;

    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOr    = 4'b0001;
    localparam logic [3:0] AluSlt   = 4'b0111;
    localparam logic [3:0] AluPassB = 4'b1000;

    localparam logic [1:0] ExtSign  = 2'b00;
    localparam logic [1:0] ExtZero  = 2'b01;
    localparam logic [1:0] ExtUpper = 2'b10;

    state_e      state_q, state_d;
    logic        is_bne_q, is_bne_d;
    logic        is_sw_q, is_sw_d;
    logic [3:0]  alu_fn_q, alu_fn_d;
    logic [1:0]  ext_q, ext_d;
    logic [31:0] retired_q, retired_d;

    state_e      dec_next;
    logic [3:0]  dec_fn;
    logic [1:0]  dec_ext;

    // Instruction decode, consumed only while in DECODE.
    always_comb begin
        dec_next = StTrap;
        dec_fn   = AluAdd;
        dec_ext  = ExtSign;
        case (opcode)
            6'h00: begin
                dec_next = StExec;
                case (funct)
                    6'h20:   dec_fn = AluAdd;
                    6'h22:   dec_fn = AluSub;
                    6'h24:   dec_fn = AluAnd;
                    6'h25:   dec_fn = AluOr;
                    6'h2A:   dec_fn = AluSlt;
                    default: dec_next = StTrap;
                endcase
            end
            6'h23, 6'h2B: dec_next = StMemAdr;
            6'h04, 6'h05: dec_next = StBranch;
            6'h08: begin
                dec_next = StImmEx;
                dec_fn   = AluAdd;
                dec_ext  = ExtSign;
            end
            6'h0C: begin
                dec_next = StImmEx;
                dec_fn   = AluAnd;
                dec_ext  = ExtZero;
            end
            6'h0D: begin
                dec_next = StImmEx;
                dec_fn   = AluOr;
                dec_ext  = ExtZero;
            end
            6'h0F: begin
                dec_next = StImmEx;
                dec_fn   = AluPassB;
                dec_ext  = ExtUpper;
            end
            6'h02:   dec_next = StJump;
            default: dec_next = StTrap;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        is_bne_d = is_bne_q;
        is_sw_d  = is_sw_q;
        alu_fn_d = alu_fn_q;
        ext_d    = ext_q;
        case (state_q)
            StReset:  state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                state_d  = dec_next;
                alu_fn_d = dec_fn;
                ext_d    = dec_ext;
                is_bne_d = (opcode == 6'h05);
                is_sw_d  = (opcode == 6'h2B);
            end
            StMemAdr: state_d = is_sw_q ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StImmEx:  state_d = StImmWb;
            StMemWb, StAluWb, StBranch, StImmWb, StJump, StTrap: state_d = StFetch;
            default:  state_d = StTrap;
        endcase
    end

    // Traps complete an instruction slot but are not counted as retired.
    always_comb begin
        retired_d = retired_q;
        if (instr_done && (state_q != StTrap)) retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StReset;
            is_bne_q  <= 1'b0;
            is_sw_q   <= 1'b0;
            alu_fn_q  <= AluAdd;
            ext_q     <= ExtSign;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            is_bne_q  <= is_bne_d;
            is_sw_q   <= is_sw_d;
            alu_fn_q  <= alu_fn_d;
            ext_q     <= ext_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 4'b0000;
        pc_source  = 2'b00;
        ext_mode   = 2'b00;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = AluAdd;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                alu_ctrl  = AluAdd;
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = AluAdd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_ctrl  = alu_fn_q;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = AluSub;
                pc_source  = 2'b01;
                pc_write   = zero ^ is_bne_q;
                instr_done = 1'b1;
            end
            StImmEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = alu_fn_q;
                ext_mode  = ext_q;
            end
            StImmWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StJump: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            StTrap: begin
                trap       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state         = state_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class cycle by cycle.
module tb_mips_multicycle_control;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_source, ext_mode;
    logic [3:0]  alu_ctrl, state;
    logic        instr_done, trap;
    logic [31:0] retired_count;
    logic [20:0] ctrl_vec;

    int compared   = 0;
    int mismatched = 0;

    mips_multicycle_control dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_ctrl      (alu_ctrl),
        .pc_source     (pc_source),
        .ext_mode      (ext_mode),
        .instr_done    (instr_done),
        .trap          (trap),
        .state         (state),
        .retired_count (retired_count)
    );

    always #5 clock = ~clock;

    assign ctrl_vec = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_source, ext_mode,
                       instr_done, trap};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h20;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        chk("rst_state", state, 4'd0);
        chk("rst_outs", ctrl_vec, 21'd0);
        chk("rst_count", retired_count, 32'd0);

        // Release away from the edge; first cycle after release stays in RESET.
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rel_state", state, 4'd0);
        chk("rel_outs", ctrl_vec, 21'd0);

        // add
        step();
        chk("add_fetch", state, 4'd1);
        chk("add_fetch_memrd", mem_read, 1'b1);
        chk("add_fetch_irw", ir_write, 1'b1);
        chk("add_fetch_pcw", pc_write, 1'b1);
        chk("add_fetch_srcb", alu_src_b, 2'b01);
        chk("add_fetch_alu", alu_ctrl, 4'b0010);
        step();
        chk("add_decode", state, 4'd2);
        chk("add_decode_srcb", alu_src_b, 2'b11);
        step();
        chk("add_exec", state, 4'd7);
        chk("add_exec_alu", alu_ctrl, 4'b0010);
        chk("add_exec_srca", alu_src_a, 1'b1);
        step();
        chk("add_aluwb", state, 4'd8);
        chk("add_aluwb_rw", reg_write, 1'b1);
        chk("add_aluwb_rd", reg_dst, 1'b1);
        chk("add_aluwb_done", instr_done, 1'b1);
        step();
        chk("add_back_fetch", state, 4'd1);
        chk("add_count", retired_count, 32'd1);

        // lw with two wait cycles in MEMRD
        opcode = 6'h23;
        step();
        chk("lw_decode", state, 4'd2);
        step();
        chk("lw_memadr", state, 4'd3);
        chk("lw_memadr_srcb", alu_src_b, 2'b10);
        mem_ready = 1'b0;
        step();
        chk("lw_memrd1", state, 4'd4);
        chk("lw_memrd1_strobe", {mem_read, iord}, 2'b11);
        step();
        chk("lw_memrd2", state, 4'd4);
        chk("lw_memrd2_strobe", {mem_read, iord}, 2'b11);
        step();
        chk("lw_memrd3", state, 4'd4);
        mem_ready = 1'b1;
        #1;
        chk("lw_memrd3_strobe", {mem_read, iord}, 2'b11);
        step();
        chk("lw_memwb", state, 4'd5);
        chk("lw_memwb_m2r", {mem_to_reg, reg_write, reg_dst, instr_done}, 4'b1101);
        step();
        chk("lw_back_fetch", state, 4'd1);
        chk("lw_count", retired_count, 32'd2);

        // beq, zero toggled within the BRANCH cycle
        opcode = 6'h04;
        step();
        step();
        chk("beq_branch", state, 4'd9);
        zero = 1'b1;
        #1;
        chk("beq_z1_pcw", pc_write, 1'b1);
        chk("beq_pcsrc", pc_source, 2'b01);
        chk("beq_alu", alu_ctrl, 4'b0110);
        zero = 1'b0;
        #1;
        chk("beq_z0_pcw", pc_write, 1'b0);
        step();
        chk("beq_count", retired_count, 32'd3);

        // bne, zero=0 -> taken
        opcode = 6'h05;
        step();
        step();
        chk("bne_branch", state, 4'd9);
        chk("bne_z0_pcw", pc_write, 1'b1);
        step();
        chk("bne_count", retired_count, 32'd4);

        // lui / ori / addi
        opcode = 6'h0F;
        step();
        step();
        chk("lui_immex", state, 4'd10);
        chk("lui_ext", ext_mode, 2'b10);
        chk("lui_alu", alu_ctrl, 4'b1000);
        step();
        chk("lui_immwb", {state, reg_write, reg_dst, mem_to_reg}, {4'd11, 3'b100});
        step();
        opcode = 6'h0D;
        step();
        step();
        chk("ori_ext", ext_mode, 2'b01);
        chk("ori_alu", alu_ctrl, 4'b0001);
        step();
        step();
        opcode = 6'h08;
        step();
        step();
        chk("addi_immex", state, 4'd10);
        chk("addi_ext", ext_mode, 2'b00);
        chk("addi_alu", alu_ctrl, 4'b0010);
        step();
        step();
        chk("imm_count", retired_count, 32'd7);

        // Illegal opcode, then illegal R-type funct
        opcode = 6'h3F;
        step();
        step();
        chk("trapop_state", state, 4'd13);
        chk("trapop_flags", {trap, instr_done, reg_write, mem_write, pc_write}, 5'b11000);
        step();
        chk("trapop_cleared", trap, 1'b0);
        chk("trapop_count", retired_count, 32'd7);
        opcode = 6'h00;
        funct  = 6'h08;
        step();
        step();
        chk("trapfn_state", state, 4'd13);
        chk("trapfn_flags", {trap, instr_done}, 2'b11);
        step();
        chk("trapfn_count", retired_count, 32'd7);

        // j
        opcode = 6'h02;
        step();
        step();
        chk("j_state", state, 4'd12);
        chk("j_ctl", {pc_write, pc_source, instr_done}, 4'b1101);
        step();
        chk("j_count", retired_count, 32'd8);

        // sw, no stall
        opcode = 6'h2B;
        step();
        step();
        step();
        chk("sw_memwr", state, 4'd6);
        chk("sw_ctl", {mem_write, iord, instr_done}, 3'b111);
        step();
        chk("sw_back_fetch", state, 4'd1);
        chk("sw_count", retired_count, 32'd9);

        // sw stalled in MEMWR, then reset mid-instruction
        step();
        step();
        mem_ready = 1'b0;
        step();
        chk("swr_memwr", state, 4'd6);
        chk("swr_wait", {mem_write, iord, instr_done}, 3'b110);
        reset_n = 1'b0;
        #1;
        chk("swr_rst_state", state, 4'd0);
        chk("swr_rst_outs", ctrl_vec, 21'd0);
        chk("swr_rst_count", retired_count, 32'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("swr_rel_state", state, 4'd0);
        step();
        chk("swr_rel_fetch", state, 4'd1);

        // FETCH stall holds the read strobe but not the load enables
        mem_ready = 1'b0;
        #1;
        chk("fstall_ctl", {mem_read, ir_write, pc_write}, 3'b100);
        step();
        chk("fstall_hold", state, 4'd1);
        chk("fstall_count", retired_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
